// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared state encoding and page-addressing command bytes for oled_frame_refresh
package oled_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CMD_LOAD,
        DATA_ADDR,
        DATA_LOAD,
        SPI_START,
        SPI_WAIT,
        SPI_CLEAR,
        PAGE_NEXT,
        GAP_START,
        GAP_WAIT,
        DONE
    } state_t;

    localparam logic [7:0] CMD_SET_PAGE = 8'h22;
    localparam logic [7:0] CMD_COL_LO   = 8'h00;
    localparam logic [7:0] CMD_COL_HI   = 8'h10;
    localparam int         CMD_COUNT    = 4;

    // cmd_idx runs 0..CMD_LAST through the command bytes, then parks at CMD_DATA for pixel bytes
    localparam logic [2:0] CMD_LAST = 3'(CMD_COUNT - 1);
    localparam logic [2:0] CMD_DATA = 3'(CMD_COUNT);

    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [7:0] page);
        case (idx)
            2'd0:    cmd_byte = CMD_SET_PAGE;
            2'd1:    cmd_byte = page;
            2'd2:    cmd_byte = CMD_COL_LO;
            default: cmd_byte = CMD_COL_HI;
        endcase
    endfunction

endpackage

// File: rtl/oled_frame_refresh.sv
// rtl/oled_frame_refresh.sv - streams a framebuffer page by page to PmodOLED via SpiCtrl/Delay handshakes
// OLED_REFRESH_CONTINUOUS_EN: free-running refresh with FRAME_GAP_MS gap and one-cycle FIN per frame
module oled_frame_refresh
    import oled_pkg::*;
#(
    parameter int          PAGES        = 4,
    parameter int          COLS         = 128,
    parameter logic [11:0] FRAME_GAP_MS = 12'd16,
    localparam int         AW           = (PAGES * COLS > 1) ? $clog2(PAGES * COLS) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    output logic          FIN,
    output logic          DC,
    output logic          SPI_EN,
    output logic [7:0]    SPI_DATA,
    input  logic          SPI_FIN,
    output logic          DELAY_EN,
    output logic [11:0]   DELAY_MS,
    input  logic          DELAY_FIN,
    output logic [AW-1:0] MEM_ADDR,
    input  logic [7:0]    MEM_DATA
);

    localparam int            PW        = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int            CW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] page_q, page_d;
    logic [CW-1:0] col_q, col_d;
    logic [2:0]    cmd_idx_q, cmd_idx_d;
    logic          fin_q, fin_d;
    logic          dc_q, dc_d;
    logic          spi_en_q, spi_en_d;
    logic [7:0]    spi_data_q, spi_data_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          delay_en_q, delay_en_d;
    logic          unused_delay_fin;

    assign unused_delay_fin = DELAY_FIN;

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        col_d      = col_q;
        cmd_idx_d  = cmd_idx_q;
        dc_d       = dc_q;
        spi_en_d   = spi_en_q;
        spi_data_d = spi_data_q;
        mem_addr_d = mem_addr_q;
`ifdef OLED_REFRESH_CONTINUOUS_EN
        fin_d      = 1'b0;
        delay_en_d = delay_en_q;
`else
        fin_d      = fin_q;
        delay_en_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                page_d    = '0;
                col_d     = '0;
                cmd_idx_d = '0;
                fin_d     = 1'b0;
                if (EN) state_d = CMD_LOAD;
            end
            CMD_LOAD: begin
                dc_d       = 1'b0;
                spi_data_d = cmd_byte(cmd_idx_q[1:0], 8'(page_q));
                state_d    = SPI_START;
            end
            DATA_ADDR: state_d = DATA_LOAD;
            DATA_LOAD: begin
                dc_d       = 1'b1;
                spi_data_d = MEM_DATA;
                state_d    = SPI_START;
            end
            SPI_START: begin
                spi_en_d = 1'b1;
                state_d  = SPI_WAIT;
            end
            SPI_WAIT: begin
                // drop the request as soon as FIN lands so SpiCtrl sees it low during SPI_CLEAR
                if (SPI_FIN) begin
                    spi_en_d = 1'b0;
                    state_d  = SPI_CLEAR;
                end
            end
            SPI_CLEAR: begin
                spi_en_d = 1'b0;
                if (!EN) begin
                    state_d = IDLE;
                end else if (cmd_idx_q < CMD_LAST) begin
                    cmd_idx_d = cmd_idx_q + 3'd1;
                    state_d   = CMD_LOAD;
                end else if (cmd_idx_q == CMD_LAST) begin
                    cmd_idx_d = CMD_DATA;
                    state_d   = DATA_ADDR;
                end else if (col_q < COL_LAST) begin
                    col_d   = col_q + CW'(1);
                    state_d = DATA_ADDR;
                end else begin
                    state_d = PAGE_NEXT;
                end
            end
            PAGE_NEXT: begin
                col_d     = '0;
                cmd_idx_d = '0;
                if (page_q < PAGE_LAST) begin
                    page_d  = page_q + PW'(1);
                    state_d = CMD_LOAD;
                end else begin
                    page_d = '0;
`ifdef OLED_REFRESH_CONTINUOUS_EN
                    fin_d   = 1'b1;
                    state_d = GAP_START;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef OLED_REFRESH_CONTINUOUS_EN
            GAP_START: begin
                delay_en_d = 1'b1;
                state_d    = GAP_WAIT;
            end
            GAP_WAIT: begin
                if (DELAY_FIN) begin
                    delay_en_d = 1'b0;
                    state_d    = EN ? CMD_LOAD : IDLE;
                end
            end
`else
            DONE: begin
                fin_d = EN;
                if (!EN) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // address is presented during DATA_ADDR so the one-cycle RAM read lands in DATA_LOAD
        if (state_d == DATA_ADDR) begin
            mem_addr_d = AW'(int'(page_d) * COLS + int'(col_d));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            page_q     <= '0;
            col_q      <= '0;
            cmd_idx_q  <= '0;
            fin_q      <= 1'b0;
            dc_q       <= 1'b0;
            spi_en_q   <= 1'b0;
            spi_data_q <= 8'h00;
            mem_addr_q <= '0;
            delay_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            col_q      <= col_d;
            cmd_idx_q  <= cmd_idx_d;
            fin_q      <= fin_d;
            dc_q       <= dc_d;
            spi_en_q   <= spi_en_d;
            spi_data_q <= spi_data_d;
            mem_addr_q <= mem_addr_d;
            delay_en_q <= delay_en_d;
        end
    end

    assign FIN      = fin_q;
    assign DC       = dc_q;
    assign SPI_EN   = spi_en_q;
    assign SPI_DATA = spi_data_q;
    assign MEM_ADDR = mem_addr_q;
    assign DELAY_EN = delay_en_q;
    assign DELAY_MS = FRAME_GAP_MS;

endmodule

// File: tb/tb_oled_frame_refresh.sv
// tb/tb_oled_frame_refresh.sv - self-checking bench for oled_frame_refresh with SpiCtrl, Delay and RAM models
module tb_oled_frame_refresh;

    localparam int PAGES  = 4;
    localparam int COLS   = 128;
    localparam int PAGE_B = 4 + COLS;
    localparam int NBYTES = PAGES * PAGE_B;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic        fin, dc, spi_en, spi_fin, delay_en;
    logic        delay_fin = 1'b0;
    logic [7:0]  spi_data;
    logic [7:0]  mem_data;
    logic [11:0] delay_ms;
    logic [8:0]  mem_addr;

    always #5 clk = ~clk;

    oled_frame_refresh #(.PAGES(PAGES), .COLS(COLS), .FRAME_GAP_MS(12'd16)) dut (
        .CLK(clk), .RST(rst_n), .EN(en), .FIN(fin), .DC(dc),
        .SPI_EN(spi_en), .SPI_DATA(spi_data), .SPI_FIN(spi_fin),
        .DELAY_EN(delay_en), .DELAY_MS(delay_ms), .DELAY_FIN(delay_fin),
        .MEM_ADDR(mem_addr), .MEM_DATA(mem_data)
    );

    int asserts = 0;
    int fails   = 0;

    logic [7:0] ram [PAGES*COLS];
    always @(posedge clk) mem_data <= ram[mem_addr];

    typedef struct { logic dc; logic [7:0] data; int gap; } xfer_t;
    xfer_t got_q[$];

    bit         early_mode = 1'b0;
    bit         rand_lat   = 1'b0;
    logic       fin_reg    = 1'b0;
    bit         busy       = 1'b0;
    int         cnt        = 0;
    int         low_cnt    = 0;
    int         started    = 0;
    int         stable_err = 0;
    int         fin_cnt    = 0;
    int         dcnt       = 0;
    logic       cur_dc     = 1'b0;
    logic [7:0] cur_data   = 8'h00;
    int         cur_gap    = 0;

    // early_mode raises FIN whenever no request is pending, so it is present during SPI_START
    assign spi_fin = fin_reg | (early_mode & ~spi_en);

    always @(posedge clk) begin
        if (!rst_n) begin
            fin_reg <= 1'b0;
            busy    <= 1'b0;
            low_cnt <= 0;
        end else if (!busy) begin
            if (spi_en) begin
                busy     <= 1'b1;
                cnt      <= rand_lat ? int'($urandom_range(20, 1)) : 16;
                cur_dc   <= dc;
                cur_data <= spi_data;
                cur_gap  <= low_cnt;
                low_cnt  <= 0;
                started  <= started + 1;
            end else begin
                low_cnt <= low_cnt + 1;
            end
        end else if (!fin_reg) begin
            if (cnt <= 1) fin_reg <= 1'b1;
            else cnt <= cnt - 1;
            if (spi_data !== cur_data || dc !== cur_dc) stable_err <= stable_err + 1;
        end else if (!spi_en) begin
            fin_reg <= 1'b0;
            busy    <= 1'b0;
            low_cnt <= 1;
            got_q.push_back('{cur_dc, cur_data, cur_gap});
        end
    end

    always @(posedge clk) begin
        if (!delay_en) begin
            dcnt      <= 0;
            delay_fin <= 1'b0;
        end else if (dcnt >= 5) begin
            delay_fin <= 1'b1;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    always @(posedge clk) if (fin === 1'b1) fin_cnt <= fin_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fin(input int budget, input string name);
        int n = 0;
        while (fin !== 1'b1 && n < budget) begin tick(); n++; end
        check(name, 32'(fin), 32'd1);
    endtask

    task automatic wait_started(input int target, input int budget, input string name);
        int n = 0;
        while (started < target && n < budget) begin tick(); n++; end
        check(name, 32'(started >= target), 32'd1);
    endtask

    task automatic wait_got(input int target, input int budget, input string name);
        int n = 0;
        while (got_q.size() < target && n < budget) begin tick(); n++; end
        check(name, 32'(got_q.size() >= target), 32'd1);
    endtask

    // expected stream: per page 22,p,00,10 then COLS RAM bytes; 3 idle cycles before a
    // command byte, 4 before a data byte or the first command of a new page
    task automatic check_frame(input int base, input string tag);
        int         n, p, j, egap;
        logic       edc;
        logic [7:0] edata;
        xfer_t      g;
        n = got_q.size() - base;
        check({tag, "_len"}, 32'(n), 32'(NBYTES));
        if (n > NBYTES) n = NBYTES;
        for (int k = 0; k < n; k++) begin
            p    = k / PAGE_B;
            j    = k % PAGE_B;
            edc  = (j >= 4);
            case (j)
                0:       edata = 8'h22;
                1:       edata = 8'(p);
                2:       edata = 8'h00;
                3:       edata = 8'h10;
                default: edata = ram[p * COLS + j - 4];
            endcase
            egap = (j >= 1 && j <= 3) ? 3 : 4;
            g    = got_q[base + k];
            if (k == 0)
                check($sformatf("%s_byte%0d", tag, k), {23'd0, g.dc, g.data}, {23'd0, edc, edata});
            else
                check($sformatf("%s_byte%0d", tag, k), {15'd0, 8'(g.gap), g.dc, g.data},
                      {15'd0, 8'(egap), edc, edata});
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       spi_en;
        logic [7:0] spi_data;
        logic       dc;
        logic       fin;
        logic [8:0] mem_addr;
        logic       delay_en;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int    base, s0, fb;
        xfer_t g;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0};

        for (int i = 0; i < PAGES * COLS; i++) ram[i] = 8'(i);

        for (int i = 0; i < 6; i++) begin
            rst_n = vecs[i].rst_n;
            en    = vecs[i].en;
            tick();
            check($sformatf("vec%0d", i),
                  {11'd0, spi_en, spi_data, dc, fin, mem_addr, delay_en},
                  {11'd0, vecs[i].spi_en, vecs[i].spi_data, vecs[i].dc, vecs[i].fin,
                   vecs[i].mem_addr, vecs[i].delay_en});
        end
        check("delay_ms", 32'(delay_ms), 32'h010);

        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // full frame, fixed 16-cycle SpiCtrl
        base = got_q.size();
        en   = 1'b1;
        wait_fin(30000, "frame1_fin");
        check_frame(base, "frame1");
`ifdef OLED_REFRESH_CONTINUOUS_EN
        tick();
        check("fin_pulse", 32'(fin), 32'd0);
        check("gap_delay_en", 32'(delay_en), 32'd1);
        check("gap_delay_ms", 32'(delay_ms), 32'h010);
        base = got_q.size();
        wait_got(base + 2, 400, "frame2_start");
        if (got_q.size() >= base + 2) begin
            g = got_q[base];
            check("frame2_b0", {23'd0, g.dc, g.data}, {23'd0, 1'b0, 8'h22});
            g = got_q[base + 1];
            check("frame2_b1", {23'd0, g.dc, g.data}, {23'd0, 1'b0, 8'h00});
        end
        en = 1'b0;
        repeat (60) tick();
`else
        repeat (5) tick();
        check("fin_held", 32'(fin), 32'd1);
        check("done_spi_en", 32'(spi_en), 32'd0);
        check("done_delay_en", 32'(delay_en), 32'd0);
        en = 1'b0;
        tick();
        check("fin_clear", 32'(fin), 32'd0);
`endif

        // random RAM, random latency, FIN present during SPI_START
        for (int i = 0; i < PAGES * COLS; i++) ram[i] = 8'($urandom);
        early_mode = 1'b1;
        rand_lat   = 1'b1;
        tick();
        base = got_q.size();
        en   = 1'b1;
        wait_fin(30000, "rand_fin");
        check_frame(base, "rand");
        en = 1'b0;
        repeat (40) tick();
        early_mode = 1'b0;
        rand_lat   = 1'b0;
        check("stable_during_xfer", 32'(stable_err), 32'd0);

        // abort during page 2 data byte 10
        for (int i = 0; i < PAGES * COLS; i++) ram[i] = 8'(i);
        repeat (5) tick();
        base = got_q.size();
        s0   = started;
        fb   = fin_cnt;
        en   = 1'b1;
        wait_started(s0 + 2 * PAGE_B + 4 + 10 + 1, 30000, "abort_reach");
        en = 1'b0;
        repeat (60) tick();
        check("abort_len", 32'(got_q.size() - base), 32'(2 * PAGE_B + 4 + 10 + 1));
        g = got_q[got_q.size() - 1];
        check("abort_last", {23'd0, g.dc, g.data}, {23'd0, 1'b1, 8'h0A});
        check("abort_no_fin", 32'(fin_cnt - fb), 32'd0);
        check("abort_spi_en", 32'(spi_en), 32'd0);

        // restart after abort begins again at page 0
        base = got_q.size();
        s0   = started;
        en   = 1'b1;
        wait_got(base + 2, 400, "restart_bytes");
        if (got_q.size() >= base + 2) begin
            g = got_q[base];
            check("restart_b0", {23'd0, g.dc, g.data}, {23'd0, 1'b0, 8'h22});
            g = got_q[base + 1];
            check("restart_b1", {23'd0, g.dc, g.data}, {23'd0, 1'b0, 8'h00});
        end

        // reset while waiting on page 1 column 3
        wait_started(s0 + PAGE_B + 4 + 3 + 1, 30000, "rst_reach");
        repeat (3) tick();
        check("pre_rst_addr", {22'd0, spi_en, mem_addr}, {22'd0, 1'b1, 9'd131});
        rst_n = 1'b0;
        tick();
        check("rst_wait", {12'd0, spi_en, spi_data, dc, fin, mem_addr},
              {12'd0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0});
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        fb = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (spi_en !== 1'b0) fb++;
        end
        check("post_rst_idle", 32'(fb), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
